// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: sync hunt, data assembly, even-parity check
//
// Purpose: hunts a serial bit stream for a SYNC_LEN-bit sync pattern, then
// assembles WIDTH data bits (MSB first) followed by one even-parity bit.
// Each completed frame updates dataOut/parityErr, pulses dataValid for one
// cycle and increments frameCount.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   shiftIn    in   1      serial input bit, sampled each rising edge
//   dataOut    out  WIDTH  last assembled word
//   dataValid  out  1      one-cycle pulse when dataOut updates
//   parityErr  out  1      even-parity error for the word in dataOut
//   busy       out  1      high while in DATA or PARITY
//   frameCount out  8      completed frames, wraps modulo 256

module serial_frame_rx #(
    parameter int                    WIDTH    = 8,
    parameter int                    SYNC_LEN = 4,
    parameter logic [SYNC_LEN-1:0]   SYNC     = 4'b1101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shiftIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic             parityErr,
    output logic             busy,
    output logic [7:0]       frameCount
);

    localparam int FW = $clog2(SYNC_LEN + 1);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q;
    logic [SYNC_LEN-1:0] window_q;
    logic [FW-1:0]       fill_q;
    logic [BW-1:0]       bit_q;
    logic [WIDTH-1:0]    data_q;

    logic [SYNC_LEN-1:0] window_d;
    logic                sync_hit;

    // The incoming bit completes the window on this very edge, so the match
    // looks at the shifted value rather than the stored one.
    assign window_d = {window_q[SYNC_LEN-2:0], shiftIn};
    assign sync_hit = (window_d == SYNC) && (fill_q >= FW'(SYNC_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            window_q   <= '0;
            fill_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            dataOut    <= '0;
            dataValid  <= 1'b0;
            parityErr  <= 1'b0;
            busy       <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            dataValid <= 1'b0;
            case (state_q)
                HUNT: begin
                    window_q <= window_d;
                    if (fill_q != FW'(SYNC_LEN))
                        fill_q <= fill_q + FW'(1);
                    if (sync_hit) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                DATA: begin
                    data_q <= {data_q[WIDTH-2:0], shiftIn};
                    bit_q  <= bit_q + BW'(1);
                    if (bit_q == BW'(WIDTH - 1))
                        state_q <= PARITY;
                end
                PARITY: begin
                    dataOut    <= data_q;
                    parityErr  <= (^data_q) ^ shiftIn;
                    frameCount <= frameCount + 8'd1;
                    dataValid  <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= HUNT;
                    // Bits of this frame must not contribute to the next sync.
                    window_q   <= '0;
                    fill_q     <= '0;
                end
                default: begin
                    state_q  <= HUNT;
                    busy     <= 1'b0;
                    window_q <= '0;
                    fill_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx

module tb_serial_frame_rx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             shiftIn;
    logic [WIDTH-1:0] dataOut;
    logic             dataValid;
    logic             parityErr;
    logic             busy;
    logic [7:0]       frameCount;

    serial_frame_rx #(.WIDTH(WIDTH), .SYNC_LEN(4), .SYNC(4'b1101)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .shiftIn    (shiftIn),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .parityErr  (parityErr),
        .busy       (busy),
        .frameCount (frameCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level view of the stream.
    bit         m_hunting = 1'b1;
    bit         hunt_q[$];
    int         m_word = 0;
    int         m_dcnt = 0;
    logic [7:0] e_out = '0;
    logic       e_perr = 1'b0;
    logic       e_valid = 1'b0;
    logic       e_busy = 1'b0;
    logic [7:0] e_cnt = '0;
    logic [3:0] sync_v = 4'b1101;

    int pulses = 0;
    int busy_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        hunt_q.delete();
        m_word = 0;
        m_dcnt = 0;
        e_out = '0;
        e_perr = 1'b0;
        e_valid = 1'b0;
        e_busy = 1'b0;
        e_cnt = '0;
    endtask

    task automatic model_bit(input bit b);
        bit m;
        e_valid = 1'b0;
        if (m_hunting) begin
            hunt_q.push_back(b);
            if (hunt_q.size() >= 4) begin
                m = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (hunt_q[hunt_q.size() - 4 + i] != sync_v[3 - i]) m = 1'b0;
                if (m) begin
                    m_hunting = 1'b0;
                    m_dcnt = 0;
                    m_word = 0;
                    e_busy = 1'b1;
                end
            end
        end else if (m_dcnt < WIDTH) begin
            m_word = m_word * 2 + int'(b);
            m_dcnt++;
        end else begin
            e_out   = m_word[7:0];
            e_perr  = logic'(($countones(m_word) + int'(b)) % 2);
            e_cnt   = 8'((int'(e_cnt) + 1) % 256);
            e_valid = 1'b1;
            e_busy  = 1'b0;
            m_hunting = 1'b1;
            hunt_q.delete();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dataValid"}, 32'(dataValid), 32'(e_valid));
        chk({tag, ".dataOut"}, 32'(dataOut), 32'(e_out));
        chk({tag, ".parityErr"}, 32'(parityErr), 32'(e_perr));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".frameCount"}, 32'(frameCount), 32'(e_cnt));
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        shiftIn = b;
        @(posedge clk);
        model_bit(b);
        #1;
        if (dataValid) pulses++;
        if (busy) busy_cycles++;
        check_all("cycle");
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit p);
        send_bits(32'b1101, 4);
        send_bits(32'(d), 8);
        send_bit(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        rst_n = 1'b1;
        shiftIn = 1'b0;
        repeat (2) @(posedge clk);

        // Reset with clock running
        do_reset();
        chk("rst.dataOut", 32'(dataOut), 32'h0);
        chk("rst.frameCount", 32'(frameCount), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);

        // A5 frame, correct parity
        pulses = 0;
        busy_cycles = 0;
        send_frame(8'hA5, 1'b0);
        send_bit(1'b0);
        chk("a5.pulses", 32'(pulses), 32'd1);
        chk("a5.busy_cycles", 32'(busy_cycles), 32'd9);
        chk("a5.dataOut", 32'(dataOut), 32'hA5);
        chk("a5.parityErr", 32'(parityErr), 32'd0);
        chk("a5.frameCount", 32'(frameCount), 32'd1);

        // Same frame, bad parity
        send_frame(8'hA5, 1'b1);
        chk("a5p.dataOut", 32'(dataOut), 32'hA5);
        chk("a5p.parityErr", 32'(parityErr), 32'd1);
        chk("a5p.frameCount", 32'(frameCount), 32'd2);

        // Overlapped sync, sync pattern inside data ignored
        pulses = 0;
        send_bits(32'b0111101, 7);
        send_bits(32'hD0, 8);
        send_bit(1'b1);
        chk("d0.pulses", 32'(pulses), 32'd1);
        chk("d0.dataOut", 32'(dataOut), 32'hD0);
        chk("d0.parityErr", 32'(parityErr), 32'd0);
        chk("d0.frameCount", 32'(frameCount), 32'd3);

        // Reset mid-frame, then clean 3C frame
        pulses = 0;
        send_bits(32'b1101, 4);
        send_bits(32'b1010, 4);
        do_reset();
        send_frame(8'h3C, 1'b0);
        chk("3c.pulses", 32'(pulses), 32'd1);
        chk("3c.dataOut", 32'(dataOut), 32'h3C);
        chk("3c.frameCount", 32'(frameCount), 32'd1);

        // 256 back-to-back random frames
        do_reset();
        pulses = 0;
        for (int f = 0; f < 256; f++) begin
            d = 8'($urandom);
            send_frame(d, ^d);
        end
        chk("b2b.pulses", 32'(pulses), 32'd256);
        chk("b2b.frameCount", 32'(frameCount), 32'd0);
        chk("b2b.parityErr", 32'(parityErr), 32'd0);

        // Random bit stream with occasional embedded frames
        for (int k = 0; k < 40; k++) begin
            send_bits(32'($urandom), $urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1)
                send_frame(8'($urandom), 1'($urandom));
        end
        send_bits(32'h0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame.
REQ-002 Parameter SYNC_LEN, default 4: sync pattern length in bits.
REQ-003 Parameter SYNC, default 4'b1101: sync pattern, compared MSB-first.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 shiftIn  input  1  serial bit stream from the upstream delay line, one bit sampled per rising clk edge.
REQ-007 dataOut  output  WIDTH  last assembled data word, MSB received first.
REQ-008 dataValid  output  1  one-cycle pulse when dataOut is updated.
REQ-009 parityErr  output  1  even-parity check result for the word in dataOut; 1 = error.
REQ-010 busy  output  1  high while a frame body is being received (DATA or PARITY state).
REQ-011 frameCount  output  8  count of completed frames, wraps modulo 256.

Function
REQ-012 Frame format SHALL be SYNC (SYNC_LEN bits), then WIDTH data bits MSB first, then 1 even-parity bit; total SYNC_LEN+WIDTH+1 bits.
REQ-013 FSM SHALL have states HUNT, DATA and PARITY, and enter HUNT on reset.
REQ-014 In HUNT, each edge SHALL shift shiftIn into a SYNC_LEN-bit window and increment a fill counter saturating at SYNC_LEN.
REQ-015 Sync match SHALL be {window[SYNC_LEN-2:0], shiftIn} == SYNC with fill counter >= SYNC_LEN-1; on that edge -> DATA, bit counter = 0.
REQ-016 Sync detection SHALL allow overlap in HUNT (e.g. 11101 matches at the final bit).
REQ-017 In DATA, each edge SHALL shift shiftIn into the data register LSB side; after the WIDTH-th bit -> PARITY.
REQ-018 Data bits SHALL never be examined for sync; a SYNC pattern inside data is ignored.
REQ-019 On the PARITY edge: dataOut = assembled word; parityErr = XOR(word) XOR shiftIn; frameCount += 1 (255 -> 0); -> HUNT.
REQ-020 dataValid SHALL be high for exactly the one cycle following the PARITY edge, low otherwise.
REQ-021 dataOut and parityErr SHALL hold their values until the next completed frame.
REQ-022 On entering HUNT from PARITY, window and fill counter SHALL clear; parity/data bits never count toward the next sync.
REQ-023 busy SHALL equal (state == DATA or state == PARITY), registered with the state.
REQ-024 Latency: dataValid SHALL rise one cycle after the edge sampling the parity bit, i.e. SYNC_LEN+WIDTH+1 edges after the edge sampling the first sync bit.
REQ-025 Frames SHALL be back-to-back capable: the sync of frame N+1 may start on the edge immediately after the PARITY edge of frame N.

Reset
REQ-026 rst_n low SHALL immediately (without a clock) force state HUNT; window, fill counter, bit counter and data register 0; dataOut 0; dataValid 0; parityErr 0; busy 0; frameCount 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no dataValid pulse and no frameCount change.
REQ-028 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification (WIDTH=8, SYNC=4'b1101)
REQ-029 Assert rst_n=0 with clk running -> all outputs 0, busy 0.
REQ-030 Apply 1101, 10100101, parity 0 -> one dataValid pulse, dataOut=8'hA5, parityErr=0, frameCount=1, busy high for exactly 9 cycles.
REQ-031 Apply the same frame with parity 1 -> dataOut=8'hA5, parityErr=1, frameCount increments.
REQ-032 Apply 0111101, then data 11010000, parity 1 -> sync detected by overlap, no re-sync on the 1101 inside data, dataOut=8'hD0, parityErr=0.
REQ-033 Drop rst_n after 4 data bits, release it, then send a full 8'h3C frame with parity 0 -> no pulse for the aborted frame, dataOut=8'h3C, frameCount=1.
REQ-034 Send 256 back-to-back valid frames -> 256 dataValid pulses, frameCount wraps to 0.
